// File: rtl/pipe_skid_stage.sv
// ============================================================================
// pipe_skid_stage : two-entry elastic pipeline register with flush-to-NOP and a
//                   saturating flush-drop counter. Rev 1.0
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
  parameter int          DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int          DROP_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                in_fire;
  logic                out_fire;
  logic [1:0]          drops;
  logic [DROP_W:0]     drop_sum;

  // in_ready depends only on registered state, never on out_ready
  assign in_ready  = !reset && (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign count     = state_q;
  assign drop_cnt  = drop_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // An entry delivered in the flush cycle is not a drop; the accepted input is
  assign drops    = count - {1'b0, out_fire} + {1'b0, in_fire};
  assign drop_sum = {1'b0, drop_q} + (DROP_W+1)'(drops);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    drop_d  = drop_q;

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
      drop_d  = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (in_fire && out_fire) begin
            main_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      drop_q  <= drop_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
// tb_pipe_skid_stage : directed self-checking bench for pipe_skid_stage. Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

  localparam int               DATA_W = 16;
  localparam logic [15:0]      NOP    = 16'hDEAD;
  localparam int               DROP_W = 2;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        count;
  logic [DROP_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  pipe_skid_stage #(
    .DATA_W   (DATA_W),
    .NOP_VALUE(NOP),
    .DROP_W   (DROP_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load A then B with downstream stalled, leaving the stage FULL
  task automatic fill_ab();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A;
    tick();
    in_data   = 16'h000B;
    tick();
    in_valid  = 1'b0;
    #1;
  endtask

  logic [1:0] sat_exp [3];

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset held two cycles
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'(NOP));
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming 1..4 with no backpressure
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 16'(i);
      tick();
      chk($sformatf("stream_data_%0d", i), 32'(out_data), 32'(i));
      chk($sformatf("stream_count_%0d", i), 32'(count), 32'd1);
      chk($sformatf("stream_ready_%0d", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_count", 32'(count), 32'd0);
    chk("stream_drain_valid", 32'(out_valid), 32'd0);
    chk("stream_drain_data", 32'(out_data), 32'(NOP));

    // Backpressure: A, B held, then released in order
    fill_ab();
    chk("bp_count_full", 32'(count), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_a", 32'(out_data), 32'h000A);
    tick();
    chk("bp_hold_a_again", 32'(out_data), 32'h000A);
    chk("bp_count_hold", 32'(count), 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_emit_a", 32'(out_data), 32'h000A);
    tick();
    chk("bp_emit_b", 32'(out_data), 32'h000B);
    chk("bp_count_one", 32'(count), 32'd1);
    tick();
    chk("bp_count_zero", 32'(count), 32'd0);
    chk("bp_drop_none", 32'(drop_cnt), 32'd0);

    // Flush while FULL, with an input offered that must not be accepted
    fill_ab();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h000C;
    #1;
    chk("flfull_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flfull_count", 32'(count), 32'd0);
    chk("flfull_out_data", 32'(out_data), 32'(NOP));
    chk("flfull_out_valid", 32'(out_valid), 32'd0);
    chk("flfull_drop", 32'(drop_cnt), 32'd2);

    // Flush with a concurrent delivery: held entry counts as delivered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000D;
    tick();
    out_ready = 1'b1;
    in_data   = 16'h000E;
    flush     = 1'b1;
    #1;
    chk("flfire_out_valid", 32'(out_valid), 32'd1);
    chk("flfire_out_data", 32'(out_data), 32'h000D);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("flfire_count", 32'(count), 32'd0);
    chk("flfire_drop", 32'(drop_cnt), 32'd3);

    // Reset mid-operation clears entries and drop counter
    in_valid = 1'b1;
    in_data  = 16'h0011;
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_drop", 32'(drop_cnt), 32'd0);
    chk("midrst_data", 32'(out_data), 32'(NOP));

    // Flush from ONE with an accepted input and no delivery: two drops
    in_valid = 1'b1;
    in_data  = 16'h0021;
    tick();
    in_data  = 16'h0022;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flone_drop", 32'(drop_cnt), 32'd2);
    chk("flone_count", 32'(count), 32'd0);

    // Saturation: repeated FULL flushes from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sat_exp[0] = 2'd2;
    sat_exp[1] = 2'd3;
    sat_exp[2] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      fill_ab();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk($sformatf("sat_drop_%0d", k), 32'(drop_cnt), 32'(sat_exp[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
